// File: rtl/mem_responder.sv
// mem_responder: multi-cycle data-memory slave for the CPU load/store port.
// The responder takes a request in IDLE and counts WAIT_CYCLES wait states.
// It then returns a one-cycle mem_ready pulse, with mem_error raised on a fault.
// The request inputs are not sampled in the RESP cycle, so the requester can
// keep its request asserted until it sees mem_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   MemRead    read request (held until mem_ready)
//   MemWrite   write request (held until mem_ready)
//   Address    byte address; word index = Address[ADDR_W-1:2]
//   Write_data write data, captured with the request
//   Read_data  registered read result; changes only on a successful read
//   mem_ready  one-cycle completion pulse
//   mem_error  fault flag, valid only while mem_ready=1 (0 otherwise)
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Write_data,
    output logic [DATA_W-1:0] Read_data,
    output logic              mem_ready,
    output logic              mem_error
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, next_state;
    logic [3:0]        cnt;
    logic              op_rd, op_wr, err_q;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic [IDX_W-1:0]  idx_in;
    logic              fault_in;
    logic              sel_live;
    logic              eff_rd, eff_wr, eff_err;
    logic [AW-1:0]     eff_idx;
    logic [DATA_W-1:0] eff_wd;
    logic              enter_resp;

    assign req      = MemRead | MemWrite;
    assign idx_in   = Address[ADDR_W-1:2];
    assign fault_in = (MemRead & MemWrite) | (Address[1:0] != 2'b00) |
                      (idx_in >= IDX_W'(DEPTH));

    // With WAIT_CYCLES=0, RESP is entered on the same edge that samples the
    // request, so the commit must use the live inputs rather than the captured copy.
    assign sel_live = (state == IDLE);
    assign eff_rd   = sel_live ? MemRead          : op_rd;
    assign eff_wr   = sel_live ? MemWrite         : op_wr;
    assign eff_err  = sel_live ? fault_in         : err_q;
    assign eff_idx  = sel_live ? idx_in[AW-1:0]   : idx_q;
    assign eff_wd   = sel_live ? Write_data       : wdata_q;

    assign enter_resp = (next_state == RESP) && (state != RESP);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = (WAIT_CYCLES == 0) ? RESP : BUSY;
            BUSY:    if (cnt == 4'd1) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: both are decoded from registered state, so they are glitch-free
    always_comb begin
        mem_ready = (state == RESP);
        mem_error = (state == RESP) && err_q;
    end

    // Wait counter and request capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            op_rd   <= 1'b0;
            op_wr   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && req) begin
            cnt     <= 4'(WAIT_CYCLES);
            op_rd   <= MemRead;
            op_wr   <= MemWrite;
            err_q   <= fault_in;
            idx_q   <= idx_in[AW-1:0];
            wdata_q <= Write_data;
        end else if (state == BUSY) begin
            cnt     <= cnt - 4'd1;
        end
    end

    // Read result: only a fault-free read updates it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            Read_data <= '0;
        else if (enter_resp && eff_rd && !eff_err)
            Read_data <= mem[eff_idx];
    end

    // Storage array (not reset). A write commits on RESP entry. If reset
    // aborts the access first, the write is dropped.
    always_ff @(posedge clk) begin
        if (enter_resp && eff_wr && !eff_err)
            mem[eff_idx] <= eff_wd;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Two instances run here: one with WAIT_CYCLES=2
// and one with WAIT_CYCLES=0. Expected {err, Read_data} pairs are pushed to
// a queue for each instance when a request is driven. The queue entries are
// popped on every mem_ready pulse.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] Address = '0, Write_data = '0;
    logic [31:0] Read_data;
    logic        mem_ready, mem_error;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = '0, wd0 = '0;
    logic [31:0] rdata0;
    logic        rdy0, err0;

    mem_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
        .mem_ready(mem_ready), .mem_error(mem_error)
    );

    mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0),
        .Address(addr0), .Write_data(wd0), .Read_data(rdata0),
        .mem_ready(rdy0), .mem_error(err0)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: one array and one last-read register per instance
    logic [31:0] mem2 [int];
    logic [31:0] mem0 [int];
    logic [31:0] rd2m = '0, rd0m = '0;
    logic [32:0] q2 [$];
    logic [32:0] q0 [$];
    logic [32:0] e2, e0;

    task automatic predict(input bit which, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [32:0] e);
        logic err;
        int idx;
        logic [31:0] r;
        err = (rd && wr) || (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        idx = int'(a[31:2]);
        r   = which ? rd2m : rd0m;
        if (!err) begin
            if (wr) begin
                if (which) mem2[idx] = wd; else mem0[idx] = wd;
            end
            if (rd) r = which ? mem2[idx] : mem0[idx];
        end
        if (which) rd2m = r; else rd0m = r;
        e = {err, r};
    endtask

    // Scoreboard monitors
    always @(negedge clk) if (reset) begin
        if (mem_ready) begin
            if (q2.size() == 0) chk("w2_spurious_ready", mem_ready, 0);
            else begin
                e2 = q2.pop_front();
                chk("w2_rdata", Read_data, e2[31:0]);
                chk("w2_err", mem_error, e2[32]);
            end
        end else chk("w2_err_idle", mem_error, 0);
    end

    always @(negedge clk) if (reset) begin
        if (rdy0) begin
            if (q0.size() == 0) chk("w0_spurious_ready", rdy0, 0);
            else begin
                e0 = q0.pop_front();
                chk("w0_rdata", rdata0, e0[31:0]);
                chk("w0_err", err0, e0[32]);
            end
        end else chk("w0_err_idle", err0, 0);
    end

    // One WAIT_CYCLES=2 access, starting at a negedge. If chg is set, Address
    // switches to a2 after the request has been sampled.
    task automatic acc(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input bit chg, input logic [31:0] a2);
        logic [32:0] e;
        int n;
        bit got;
        predict(1'b1, rd, wr, a, wd, e);
        q2.push_back(e);
        MemRead = rd; MemWrite = wr; Address = a; Write_data = wd;
        n = 0; got = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (mem_ready) got = 1;
            else if (chg && n == 1) begin
                Address = a2;
                Write_data = ~wd;
            end
        end
        chk("w2_ready_seen", 64'(got), 1);
        chk("w2_latency", n, 3);
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        chk("w2_ready_fall", mem_ready, 0);
    endtask

    // One WAIT_CYCLES=0 access: ready is expected right after the sampling edge
    task automatic acc0(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd);
        logic [32:0] e;
        predict(1'b0, rd, wr, a, wd, e);
        q0.push_back(e);
        rd0 = rd; wr0 = wr; addr0 = a; wd0 = wd;
        @(negedge clk);
        chk("w0_ready", rdy0, 1);
        rd0 = 1'b0; wr0 = 1'b0;
        @(negedge clk);
        chk("w0_ready_fall", rdy0, 0);
    endtask

    initial begin
        int nr;
        logic [32:0] e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rdata", Read_data, 0);
        chk("rst_ready", mem_ready, 0);
        chk("rst_err", mem_error, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_ready0", rdy0, 0);
        reset = 1'b1;

        nr = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_ready || rdy0) nr++;
        end
        chk("idle_no_ready", nr, 0);

        // Basic write then read-after-write
        acc(0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
        acc(1, 0, 32'h10, 32'h0, 0, 0);

        // Faults keep Read_data
        acc(1, 0, 32'h13, 32'h0, 0, 0);
        acc(1, 0, 32'h400, 32'h0, 0, 0);

        // Last valid word
        acc(0, 1, 32'h3FC, 32'h0BAD_CAFE, 0, 0);
        acc(1, 0, 32'h3FC, 32'h0, 0, 0);

        // Read and write together is a fault; memory is untouched
        acc(0, 1, 32'h20, 32'h11111111, 0, 0);
        acc(1, 1, 32'h20, 32'h12345678, 0, 0);
        acc(1, 0, 32'h20, 32'h0, 0, 0);

        // Address change mid-access does not redirect the read
        acc(0, 1, 32'h14, 32'h77777777, 0, 0);
        acc(1, 0, 32'h10, 32'h0, 1, 32'h14);
        acc(1, 0, 32'h14, 32'h0, 0, 0);

        // Reset during BUSY of a write: no pulse, write dropped
        acc(0, 1, 32'h30, 32'h55AA55AA, 0, 0);
        MemWrite = 1'b1; Address = 32'h30; Write_data = 32'hCAFEF00D;
        @(negedge clk);
        reset = 1'b0;
        MemWrite = 1'b0;
        #2;
        chk("rst_mid_rdata", Read_data, 0);
        chk("rst_mid_ready", mem_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        rd2m = '0;
        rd0m = '0;
        repeat (4) @(negedge clk);
        acc(1, 0, 32'h30, 32'h0, 0, 0);

        // WAIT_CYCLES=0 instance
        acc0(0, 1, 32'h10, 32'hA5A50001);
        acc0(0, 1, 32'h14, 32'hA5A50002);
        acc0(1, 0, 32'h12, 32'h0);
        rd0 = 1'b1; addr0 = 32'h10;
        for (int i = 0; i < 4; i++) begin
            predict(1'b0, 1, 0, 32'h10, 32'h0, e);
            q0.push_back(e);
            @(negedge clk);
            chk("w0_held_hi", rdy0, 1);
            if (i == 3) addr0 = 32'h14;
            @(negedge clk);
            chk("w0_held_lo", rdy0, 0);
        end
        predict(1'b0, 1, 0, 32'h14, 32'h0, e);
        q0.push_back(e);
        @(negedge clk);
        chk("w0_held_hi", rdy0, 1);
        rd0 = 1'b0;
        @(negedge clk);
        chk("w0_held_lo", rdy0, 0);

        repeat (3) @(negedge clk);
        chk("q2_drained", q2.size(), 0);
        chk("q0_drained", q0.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle data-memory responder: the slave end of the CPU's MemRead/MemWrite/Address/Write_data/Read_data load-store interface.
- Adds a completion handshake (mem_ready) and a fault flag (mem_error), so the requester can stall on variable latency.
- Holds a word-addressed internal array.
- Sits between the CPU datapath and backing storage; drop-in replacement for the single-cycle data memory once the pipeline stalls on mem_ready.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, byte-address width.
- DEPTH, 256, number of DATA_W words stored.
- WAIT_CYCLES, 2, wait states per access (legal range 0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- MemRead  input  1  read request; held by the requester until mem_ready.
- MemWrite  input  1  write request; held by the requester until mem_ready.
- Address  input  ADDR_W  byte address; word index is Address[ADDR_W-1:2].
- Write_data  input  DATA_W  write data, sampled with the request.
- Read_data  output  DATA_W  read result; registered.
- mem_ready  output  1  one-cycle completion pulse.
- mem_error  output  1  fault status; meaningful only while mem_ready=1, else 0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, mem_ready=0, mem_error=0, Read_data=0. Array contents are not reset.
- States:
  - IDLE: waiting for a request.
  - BUSY: counting wait states.
  - RESP: one-cycle response.
- IDLE: at edge N, if MemRead|MemWrite=1, capture op, Address and Write_data, and evaluate the fault:
  - both MemRead and MemWrite=1;
  - Address[1:0]!=0;
  - word index >= DEPTH.
  - Next state is BUSY with counter=WAIT_CYCLES, or RESP directly if WAIT_CYCLES=0.
- BUSY: decrement the counter each edge; when it reaches 1, go to RESP at that edge.
- Timing rule: mem_ready rises at edge N+WAIT_CYCLES and falls at edge N+WAIT_CYCLES+1. Access latency is WAIT_CYCLES+1 cycles after the sampling edge.
- Entry into RESP, no fault:
  - Write: commit the captured Write_data to array[index] at the same edge.
  - Read: load Read_data from array[index] at the same edge.
- Entry into RESP, fault: mem_error=1, no array write, Read_data unchanged.
- RESP: always returns to IDLE at the next edge without sampling the request inputs. This absorbs the requester's held request.
  - Earliest next capture is edge N+WAIT_CYCLES+2.
  - Sustained throughput is one access per WAIT_CYCLES+2 cycles.
- Read_data holds its value until the next successful read. Writes and faults do not disturb it.
- Captured values: request inputs changing while in BUSY/RESP are ignored. The captured values are used.
- Reset mid-transaction: the pending write is dropped, the array is unchanged, and mem_ready never pulses for the aborted access.
- Read-after-write to the same address in consecutive transactions returns the new data.

Test Plan:
- Reset with reset=0, then release → Read_data=0, mem_ready=0, mem_error=0; no response while MemRead=MemWrite=0 for 20 cycles.
- WAIT_CYCLES=2: write 0xDEADBEEF to Address 0x10 sampled at edge N → mem_ready=1 exactly between edges N+2 and N+3, mem_error=0. Then read 0x10 → Read_data=0xDEADBEEF with the ready pulse, latency 3 cycles.
- Misaligned read at Address 0x13, and out-of-range read at Address 0x400 (DEPTH=256) → each gives a ready pulse with mem_error=1, Read_data keeps its previous value.
- MemRead=MemWrite=1 at Address 0x20, Write_data=0x12345678 → mem_error=1 on the ready pulse. A subsequent read of 0x20 returns the prior contents, not 0x12345678.
- Pulse reset low during BUSY of a write of 0xCAFEF00D to 0x30 → no mem_ready pulse. A following read of 0x30 returns the old value.
- WAIT_CYCLES=0 and MemRead held continuously on 0x10 → ready pulses every 2 cycles. Changing Address mid-access does not alter the in-flight result.
